// File: rtl/block_accumulator.sv
// Block reduction stage: sums the 64 products of one buffer block and hands the result downstream.
// Optional running maximum and MAX_data port when BLOCK_ACC_MAX_EN is defined.
module block_accumulator #(
   parameter int N     = 32,
   parameter int ACC_W = N + 6
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             START,
   output logic             EN_blockRead,
   input  logic             VALID_memVal,
   input  logic [N-1:0]     memVal_data,
   output logic             BUSY,
   output logic             VALID_sum,
   input  logic             RDY_sum,
   output logic [ACC_W-1:0] SUM_data
`ifdef BLOCK_ACC_MAX_EN
   ,
   output logic [N-1:0]     MAX_data
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_ACCUM = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [6:0] LAST_CNT = 7'd63;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [6:0]       beat_cnt_q, beat_cnt_d;
   logic [ACC_W-1:0] beat_ext;
   logic             first_beat;

   assign beat_ext   = {{(ACC_W - N){1'b0}}, memVal_data};
   assign first_beat = (state_q == S_REQ) && VALID_memVal;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (START) state_d = S_REQ;
         end
         S_REQ: begin
            if (VALID_memVal) begin
               acc_d      = beat_ext;
               beat_cnt_d = 7'd1;
               state_d    = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (VALID_memVal) begin
               acc_d      = acc_q + beat_ext;
               beat_cnt_d = beat_cnt_q + 7'd1;
               if (beat_cnt_q == LAST_CNT) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (RDY_sum) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef BLOCK_ACC_MAX_EN
   logic [N-1:0] max_q, max_d;

   always_comb begin
      max_d = max_q;
      if (first_beat)
         max_d = memVal_data;
      else if ((state_q == S_ACCUM) && VALID_memVal && (memVal_data > max_q))
         max_d = memVal_data;
   end

   always_ff @(posedge CLK) begin
      if (rst) max_q <= '0;
      else     max_q <= max_d;
   end

   assign MAX_data = max_q;
`else
   logic unused_first_beat;
   assign unused_first_beat = first_beat;
`endif

   // Status outputs come straight from the state register, never from inputs.
   assign EN_blockRead = (state_q == S_REQ);
   assign BUSY         = (state_q != S_IDLE);
   assign VALID_sum    = (state_q == S_DONE);
   assign SUM_data     = acc_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Randomised self-checking bench for block_accumulator against a queue-based reference model.
// Checks MAX_data as well when BLOCK_ACC_MAX_EN is defined.
module tb_block_accumulator;

   localparam int N     = 32;
   localparam int ACC_W = 38;

   logic             CLK;
   logic             rst;
   logic             START;
   logic             EN_blockRead;
   logic             VALID_memVal;
   logic [N-1:0]     memVal_data;
   logic             BUSY;
   logic             VALID_sum;
   logic             RDY_sum;
   logic [ACC_W-1:0] SUM_data;
`ifdef BLOCK_ACC_MAX_EN
   logic [N-1:0]     MAX_data;
`endif

   int checks = 0;
   int errors = 0;

   block_accumulator #(.N(N), .ACC_W(ACC_W)) dut (
      .CLK          (CLK),
      .rst          (rst),
      .START        (START),
      .EN_blockRead (EN_blockRead),
      .VALID_memVal (VALID_memVal),
      .memVal_data  (memVal_data),
      .BUSY         (BUSY),
      .VALID_sum    (VALID_sum),
      .RDY_sum      (RDY_sum),
      .SUM_data     (SUM_data)
`ifdef BLOCK_ACC_MAX_EN
      ,
      .MAX_data     (MAX_data)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the block is the list of accepted beats; results are its sum and max.
   int          ph = 0;  // 0 idle, 1 waiting for first beat, 2 collecting, 3 result offered
   logic [31:0] blk[$];
   logic [63:0] m_sum = '0;
   logic [31:0] m_max = '0;

   always @(posedge CLK) begin
      if (rst) begin
         ph = 0;
         blk.delete();
      end else begin
         case (ph)
            0: if (START) ph = 1;
            1: if (VALID_memVal) begin
                  blk.delete();
                  blk.push_back(memVal_data);
                  ph = 2;
               end
            2: if (VALID_memVal) begin
                  blk.push_back(memVal_data);
                  if (blk.size() == 64) ph = 3;
               end
            3: if (RDY_sum) ph = 0;
            default: ph = 0;
         endcase
      end
      m_sum = '0;
      m_max = '0;
      foreach (blk[i]) begin
         m_sum = m_sum + {32'd0, blk[i]};
         if (blk[i] > m_max) m_max = blk[i];
      end
   end

   always @(posedge CLK) begin
      #1;
      check("en_blockread", {63'd0, EN_blockRead}, {63'd0, ph == 1});
      check("busy",         {63'd0, BUSY},         {63'd0, ph != 0});
      check("valid_sum",    {63'd0, VALID_sum},    {63'd0, ph == 3});
      check("sum_data",     {26'd0, SUM_data},     m_sum);
`ifdef BLOCK_ACC_MAX_EN
      check("max_data",     {32'd0, MAX_data},     {32'd0, m_max});
`endif
   end

   function automatic logic [N-1:0] beat_val(input int mode, input int i);
      case (mode)
         0: return 32'd1;
         1: return 32'(i);
         2: return 32'hFFFF_FFFF;
         4: return 32'd2;
         default: return ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
      endcase
   endfunction

   function automatic bit gap_after(input int mode, input int i);
      if (mode == 1) return (i % 8) == 7;
      if (mode == 3) return $urandom_range(0, 3) == 0;
      return 1'b0;
   endfunction

   task automatic start_block();
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic send_beats(input int mode, input int count);
      for (int i = 0; i < count; i++) begin
         VALID_memVal = 1'b1;
         memVal_data  = beat_val(mode, i);
         @(negedge CLK);
         if (gap_after(mode, i)) begin
            VALID_memVal = 1'b0;
            memVal_data  = 32'($urandom);
            @(negedge CLK);
         end
      end
      VALID_memVal = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!VALID_sum && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check("wait_done", {63'd0, VALID_sum}, 64'd1);
   endtask

   // Hold off the result, poking START and beats that must be ignored, then accept it.
   task automatic handshake(input int hold);
      logic [ACC_W-1:0] held;
      held = SUM_data;
      for (int c = 0; c < hold; c++) begin
         RDY_sum      = 1'b0;
         START        = 1'($urandom_range(0, 1));
         VALID_memVal = 1'($urandom_range(0, 1));
         memVal_data  = 32'($urandom);
         @(negedge CLK);
         check("hold_valid", {63'd0, VALID_sum}, 64'd1);
         check("hold_sum", {26'd0, SUM_data}, {26'd0, held});
      end
      START        = 1'b0;
      VALID_memVal = 1'b0;
      RDY_sum      = 1'b1;
      @(negedge CLK);
      RDY_sum = 1'b0;
      check("post_hs_valid", {63'd0, VALID_sum}, 64'd0);
      check("post_hs_busy", {63'd0, BUSY}, 64'd0);
      check("post_hs_sum_held", {26'd0, SUM_data}, {26'd0, held});
   endtask

   task automatic stray_beats(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         VALID_memVal = 1'($urandom_range(0, 1));
         memVal_data  = 32'($urandom);
         @(negedge CLK);
         check("stray_busy", {63'd0, BUSY}, 64'd0);
      end
      VALID_memVal = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      START        = 1'b0;
      VALID_memVal = 1'b0;
      memVal_data  = '0;
      RDY_sum      = 1'b0;
      repeat (3) @(negedge CLK);
      rst = 1'b0;
      check("reset_sum", {26'd0, SUM_data}, 64'd0);
      check("reset_busy", {63'd0, BUSY}, 64'd0);

      // All ones, back-to-back beats: result must be offered right after beat 64
      start_block();
      check("req_en", {63'd0, EN_blockRead}, 64'd1);
      send_beats(0, 64);
      check("ones_latency_valid", {63'd0, VALID_sum}, 64'd1);
      check("ones_sum", {26'd0, SUM_data}, 64'd64);
`ifdef BLOCK_ACC_MAX_EN
      check("ones_max", {32'd0, MAX_data}, 64'd1);
`endif
      handshake(0);

      // Ramp with a gap after every 8th beat
      start_block();
      send_beats(1, 64);
      wait_done();
      check("ramp_sum", {26'd0, SUM_data}, 64'd2016);
`ifdef BLOCK_ACC_MAX_EN
      check("ramp_max", {32'd0, MAX_data}, 64'd63);
`endif
      handshake(1);

      // Full scale, plus backpressure with ignored START/beats
      start_block();
      send_beats(2, 64);
      wait_done();
      check("full_sum", {26'd0, SUM_data}, 64'h3F_FFFF_FFC0);
`ifdef BLOCK_ACC_MAX_EN
      check("full_max", {32'd0, MAX_data}, 64'hFFFF_FFFF);
`endif
      handshake(5);

      // Reset mid-block, then a clean block of twos
      start_block();
      send_beats(3, 10);
      VALID_memVal = 1'b1;
      memVal_data  = 32'h1234_5678;
      rst          = 1'b1;
      @(negedge CLK);
      rst          = 1'b0;
      VALID_memVal = 1'b0;
      check("rst_mid_en", {63'd0, EN_blockRead}, 64'd0);
      check("rst_mid_busy", {63'd0, BUSY}, 64'd0);
      check("rst_mid_valid", {63'd0, VALID_sum}, 64'd0);
      check("rst_mid_sum", {26'd0, SUM_data}, 64'd0);
      stray_beats(4);
      start_block();
      send_beats(4, 64);
      wait_done();
      check("twos_sum", {26'd0, SUM_data}, 64'd128);
      handshake(2);

      // Stray beats in IDLE, then randomised blocks checked by the model
      stray_beats(6);
      for (int b = 0; b < 8; b++) begin
         stray_beats($urandom_range(0, 3));
         start_block();
         send_beats(3, 64);
         wait_done();
         handshake($urandom_range(0, 4));
      end

      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
